alu_cmd_seq: RTL and testbench

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_cmd_seq.sv | 190 +++++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: accepts one ALU command at a time, decodes ALUOp/funct into an
// ALU control code, presents registered operands to an external combinational
// ALU, captures its result and holds it until the consumer takes it.
// Sequence per command: IDLE (accept) -> EXEC (ALU evaluates) -> DONE (present).
module alu_cmd_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // ALU control codes understood by the datapath ALU
  localparam logic [3:0] CTL_AND = 4'd0;
  localparam logic [3:0] CTL_OR  = 4'd1;
  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_SLT = 4'd7;
  localparam logic [3:0] CTL_NOR = 4'd12;
  localparam logic [3:0] CTL_ILL = 4'd15;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_exec_end;
  logic             w_handshake;
  logic [3:0]       w_dec_ctl;
  logic             w_dec_illegal;

  logic [3:0]       r_alu_ctl;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic             r_illegal;
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_zero;
  logic             r_res_illegal;
  logic [CNT_W-1:0] r_op_count;

  // Decode ALUOp class and R-type funct into a control code; anything unknown is illegal
  always_comb begin
    w_dec_ctl     = CTL_ILL;
    w_dec_illegal = 1'b1;
    case (in_aluop)
      2'b00: begin
        w_dec_ctl     = CTL_ADD;
        w_dec_illegal = 1'b0;
      end
      2'b01: begin
        w_dec_ctl     = CTL_SUB;
        w_dec_illegal = 1'b0;
      end
      2'b10: begin
        w_dec_illegal = 1'b0;
        case (in_funct)
          6'b100000: w_dec_ctl = CTL_ADD;
          6'b100010: w_dec_ctl = CTL_SUB;
          6'b100100: w_dec_ctl = CTL_AND;
          6'b100101: w_dec_ctl = CTL_OR;
          6'b101010: w_dec_ctl = CTL_SLT;
          6'b100111: w_dec_ctl = CTL_NOR;
          default: begin
            w_dec_ctl     = CTL_ILL;
            w_dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        w_dec_ctl     = CTL_ILL;
        w_dec_illegal = 1'b1;
      end
    endcase
  end

  // Next-state and handshake outputs; in_valid outside IDLE is simply not looked at
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    w_accept     = 1'b0;
    w_exec_end   = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec_end   = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_handshake  = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset abandons any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch decoded command on acceptance only, so the ALU inputs stay quiet otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_ctl <= 4'd0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_alu_ctl <= w_dec_ctl;
      r_alu_a   <= in_a;
      r_alu_b   <= in_b;
      r_illegal <= w_dec_illegal;
    end
  end

  // Capture the ALU result at the end of EXEC; illegal commands force a fixed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_data    <= '0;
      r_res_zero    <= 1'b0;
      r_res_illegal <= 1'b0;
    end else if (w_accept) begin
      r_res_illegal <= 1'b0;
    end else if (w_exec_end) begin
      if (r_illegal) begin
        r_res_data    <= '0;
        r_res_zero    <= 1'b1;
        r_res_illegal <= 1'b1;
      end else begin
        r_res_data    <= alu_out;
        r_res_zero    <= alu_zero;
        r_res_illegal <= 1'b0;
      end
    end
  end

  // Count results handed over, legal or not; wraps naturally at full scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_handshake) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign alu_ctl     = r_alu_ctl;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign res_data    = r_res_data;
  assign res_zero    = r_res_zero;
  assign res_illegal = r_res_illegal;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Testbench for alu_cmd_seq: directed cases plus randomized commands checked
// against an arithmetic reference model; the bench also plays the datapath ALU.
module tb_alu_cmd_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_illegal;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;

  alu_cmd_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_illegal(res_illegal),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath ALU stand-in; unknown codes give a nonzero junk value so a
  // forced illegal result is distinguishable from a passed-through one
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'd12:   alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a ^ 32'hA5A5_0001;
    endcase
  end
  assign alu_zero = (alu_out == '0);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: what the command means, straight from the instruction semantics
  task automatic ref_cmd(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic ill, output logic [3:0] ctl, output logic [31:0] r);
    ill = 1'b0;
    ctl = 4'd15;
    r   = 32'd0;
    if (op == 2'b00) begin
      ctl = 4'd2; r = a + b;
    end else if (op == 2'b01) begin
      ctl = 4'd6; r = a - b;
    end else if (op == 2'b10 && f == 6'h20) begin
      ctl = 4'd2; r = a + b;
    end else if (op == 2'b10 && f == 6'h22) begin
      ctl = 4'd6; r = a - b;
    end else if (op == 2'b10 && f == 6'h24) begin
      ctl = 4'd0; r = a & b;
    end else if (op == 2'b10 && f == 6'h25) begin
      ctl = 4'd1; r = a | b;
    end else if (op == 2'b10 && f == 6'h2A) begin
      ctl = 4'd7; r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
    end else if (op == 2'b10 && f == 6'h27) begin
      ctl = 4'd12; r = ~(a | b);
    end else begin
      ill = 1'b1; ctl = 4'd15; r = 32'd0;
    end
  endtask

  // One full command: accept, EXEC, DONE held for 'hold' cycles with a stray
  // in_valid, then handshake. Called at posedge+1 with the DUT in IDLE.
  task automatic do_cmd(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic ill;
    logic [3:0] ctl;
    logic [31:0] r;
    ref_cmd(op, f, a, b, ill, ctl, r);
    $display("cmd op=%0b funct=%02h a=%08h b=%08h hold=%0d -> ctl=%0d res=%08h ill=%0b",
             op, f, a, b, hold, ctl, r, ill);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_aluop = op; in_funct = f; in_a = a; in_b = b;
    res_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_aluop = 2'($urandom); in_funct = 6'($urandom);
    in_a = $urandom; in_b = $urandom;
    chk("exec_in_ready", in_ready, 0);
    chk("exec_res_valid", res_valid, 0);
    chk("alu_ctl", alu_ctl, ctl);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    @(posedge clk); #1;
    chk("done_res_valid", res_valid, 1);
    chk("res_data", res_data, r);
    chk("res_zero", res_zero, (r == 32'd0));
    chk("res_illegal", res_illegal, ill);
    chk("done_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_aluop = 2'b00; in_a = $urandom; in_b = $urandom;
      @(posedge clk); #1;
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, r);
      chk("bp_res_zero", res_zero, (r == 32'd0));
      chk("bp_res_illegal", res_illegal, ill);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_alu_a", alu_a, a);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    chk("op_count", op_count, exp_count);
    chk("post_res_valid", res_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_alu_ctl", alu_ctl, ctl);
    chk("post_alu_b", alu_b, b);
  endtask

  task automatic chk_reset_vals(input string where);
    $display("reset check (%s)", where);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_zero", res_zero, 0);
    chk("rst_res_illegal", res_illegal, 0);
    chk("rst_alu_ctl", alu_ctl, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_op_count", op_count, 0);
  endtask

  logic [5:0] legal_f [6];
  logic [1:0] r_op;
  logic [5:0] r_f;

  initial begin
    legal_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    rst_n = 1'b0; in_valid = 1'b0; in_aluop = 2'b00; in_funct = 6'd0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("power-on");
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("after release");

    // Directed cases
    do_cmd(2'b10, 6'h20, 32'd5, 32'd7, 0);            // R-type add
    do_cmd(2'b01, 6'h00, 32'h1234, 32'h1234, 0);      // branch equal
    do_cmd(2'b11, 6'h20, 32'h55, 32'h66, 0);          // reserved aluop
    do_cmd(2'b10, 6'h00, 32'h0, 32'h0, 1);            // unknown funct
    do_cmd(2'b00, 6'h3F, 32'hFFFF_FFFF, 32'd1, 5);    // backpressure, add wraps to 0
    do_cmd(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 0);    // slt signed: -1 < 1
    do_cmd(2'b10, 6'h27, 32'd0, 32'd0, 0);            // nor -> all ones

    // Reset while a slt is in EXEC: nothing may come out afterwards
    $display("reset during EXEC");
    in_valid = 1'b1; in_aluop = 2'b10; in_funct = 6'h2A; in_a = 32'd1; in_b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_exec_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("asserted in EXEC");
    exp_count = 0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_valid", res_valid, 0);
      chk("post_rst_count", op_count, 0);
    end

    // 16 commands from zero must wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) do_cmd(2'b00, 6'd0, i, 32'd3, 0);
    chk("wrap_to_zero", op_count, 0);

    // Randomized stream
    for (int n = 0; n < 150; n++) begin
      r_op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) r_f = 6'($urandom);
      else r_f = legal_f[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0)
        do_cmd(r_op, r_f, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
               $urandom_range(0, 3));
      else
        do_cmd(r_op, r_f, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
